// File: rtl/spi_pwm_pkg.sv
// Shared constants and types for the SPI-controlled PWM array.
// Readback is enabled by defining SPI_PWM_READBACK_EN.
package spi_pwm_pkg;

    localparam int FRAME_W = 16;

    localparam logic [6:0] ADDR_OUT_EN_LO = 7'h00;
    localparam logic [6:0] ADDR_OUT_EN_HI = 7'h01;
    localparam logic [6:0] ADDR_PWM_EN_LO = 7'h02;
    localparam logic [6:0] ADDR_PWM_EN_HI = 7'h03;
    localparam logic [6:0] ADDR_PRESCALE  = 7'h04;
    localparam logic [6:0] ADDR_DUTY_BASE = 7'h10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } rx_state_t;

endpackage

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: synchronisers, edge detect, frame FSM.
// Presents the decoded write and the read address for readback.
module spi_frame_rx
    import spi_pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk,
    input  logic       i_copi,
    input  logic       i_cs_n,
    output logic [6:0] o_addr,
    output logic [7:0] o_data,
    output logic       o_we,
    output logic       o_err,
    output logic [6:0] o_rd_addr,
    output logic       o_rd_start,
    output logic       o_sclk_fall,
    output logic       o_busy
);

    logic [SYNC_STAGES-1:0] r_sclk_s;
    logic [SYNC_STAGES-1:0] r_copi_s;
    logic [SYNC_STAGES-1:0] r_cs_s;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    rx_state_t              r_state;
    logic [4:0]             r_cnt;
    logic [15:0]            r_shift;
    logic                   r_we;
    logic                   r_err;
    logic                   r_rd_start;

    logic w_sclk;
    logic w_cs;
    logic w_sclk_rise;
    logic w_cs_fall;
    logic w_cs_rise;

    assign w_sclk      = r_sclk_s[SYNC_STAGES-1];
    assign w_cs        = r_cs_s[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_cs_fall   = ~w_cs & r_cs_d;
    assign w_cs_rise   = w_cs & ~r_cs_d;

    // Sync flops reset low so a frame in flight at reset never looks like a fresh cs_n fall.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sclk_s   <= '0;
            r_copi_s   <= '0;
            r_cs_s     <= '0;
            r_sclk_d   <= 1'b0;
            r_cs_d     <= 1'b0;
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_rd_start <= 1'b0;
        end else begin
            r_sclk_s   <= {r_sclk_s[SYNC_STAGES-2:0], i_sclk};
            r_copi_s   <= {r_copi_s[SYNC_STAGES-2:0], i_copi};
            r_cs_s     <= {r_cs_s[SYNC_STAGES-2:0], i_cs_n};
            r_sclk_d   <= w_sclk;
            r_cs_d     <= w_cs;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_rd_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_cs_rise) begin
                        r_state <= ST_COMMIT;
                        r_we    <= (r_cnt == 5'(FRAME_W)) & r_shift[15];
                        r_err   <= (r_cnt != 5'(FRAME_W));
                    end else if (w_sclk_rise && r_cnt != 5'(FRAME_W)) begin
                        r_shift    <= {r_shift[14:0], r_copi_s[SYNC_STAGES-1]};
                        r_cnt      <= r_cnt + 5'd1;
                        r_rd_start <= (r_cnt == 5'd7) & ~r_shift[6];
                    end
                end
                ST_COMMIT: begin
                    r_state <= w_cs_fall ? ST_SHIFT : ST_IDLE;
                    r_cnt   <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_addr      = r_shift[14:8];
    assign o_data      = r_shift[7:0];
    assign o_we        = r_we;
    assign o_err       = r_err;
    assign o_rd_addr   = r_shift[6:0];
    assign o_rd_start  = r_rd_start;
    assign o_sclk_fall = ~w_sclk & r_sclk_d;
    assign o_busy      = (r_state == ST_SHIFT);

endmodule

// File: rtl/spi_pwm_array.sv
// SPI-programmed PWM array with prescaled 8-bit counter and shadowed duties.
// Define SPI_PWM_READBACK_EN to enable register readback on cipo.
module spi_pwm_array
    import spi_pwm_pkg::*;
#(
    parameter int NUM_CH      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              copi,
    input  logic              cs_n,
    output logic              cipo,
    output logic [NUM_CH-1:0] out,
    output logic              frame_err
);

    localparam logic [15:0] CH_MASK  = 16'((32'd1 << NUM_CH) - 1);
    localparam logic [7:0]  DUTY_END = 8'(16 + NUM_CH);

    logic [6:0] w_addr;
    logic [7:0] w_data;
    logic       w_we;
    logic       w_err;
    logic [6:0] w_rd_addr;
    logic       w_rd_start;
    logic       w_sclk_fall;
    logic       w_busy;
    logic       w_duty_hit;
    logic       w_tick;

    logic [15:0]       r_out_en;
    logic [15:0]       r_pwm_en;
    logic [7:0]        r_prescale;
    logic [7:0]        r_pre_act;
    logic [7:0]        r_pre_cnt;
    logic [7:0]        r_cnt;
    logic [7:0]        r_duty   [NUM_CH];
    logic [7:0]        r_shadow [NUM_CH];
    logic [NUM_CH-1:0] w_pwm;
    logic [NUM_CH-1:0] r_out;

    spi_frame_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_sclk     (sclk),
        .i_copi     (copi),
        .i_cs_n     (cs_n),
        .o_addr     (w_addr),
        .o_data     (w_data),
        .o_we       (w_we),
        .o_err      (w_err),
        .o_rd_addr  (w_rd_addr),
        .o_rd_start (w_rd_start),
        .o_sclk_fall(w_sclk_fall),
        .o_busy     (w_busy)
    );

    assign w_duty_hit = (w_addr >= ADDR_DUTY_BASE) && ({1'b0, w_addr} < DUTY_END);
    assign w_tick     = (r_pre_cnt == r_pre_act);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_en   <= '0;
            r_pwm_en   <= '0;
            r_prescale <= '0;
            for (int i = 0; i < NUM_CH; i++) r_duty[i] <= '0;
        end else if (w_we) begin
            case (w_addr)
                ADDR_OUT_EN_LO: r_out_en[7:0]  <= w_data & CH_MASK[7:0];
                ADDR_OUT_EN_HI: r_out_en[15:8] <= w_data & CH_MASK[15:8];
                ADDR_PWM_EN_LO: r_pwm_en[7:0]  <= w_data & CH_MASK[7:0];
                ADDR_PWM_EN_HI: r_pwm_en[15:8] <= w_data & CH_MASK[15:8];
                ADDR_PRESCALE:  r_prescale     <= w_data;
                default: if (w_duty_hit) r_duty[w_addr[3:0]] <= w_data;
            endcase
        end
    end

    // Prescale reload happens on the tick so a new value starts a clean interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt <= '0;
            r_pre_act <= '0;
            r_cnt     <= '0;
            for (int i = 0; i < NUM_CH; i++) r_shadow[i] <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
            r_pre_act <= r_prescale;
            r_cnt     <= r_cnt + 8'd1;
            if (r_cnt == 8'hFF) begin
                for (int i = 0; i < NUM_CH; i++) r_shadow[i] <= r_duty[i];
            end
        end else begin
            r_pre_cnt <= r_pre_cnt + 8'd1;
        end
    end

    always_comb begin
        w_pwm = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pwm[i] = (r_shadow[i] == 8'hFF) || (r_cnt < r_shadow[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_out <= '0;
        else     r_out <= r_out_en[NUM_CH-1:0] & (~r_pwm_en[NUM_CH-1:0] | w_pwm);
    end

    assign out       = r_out;
    assign frame_err = w_err;

`ifdef SPI_PWM_READBACK_EN
    logic [7:0] w_rd_data;
    logic       w_rd_hit;
    logic [7:0] r_rd_sh;
    logic       r_rd_act;
    logic       r_cipo;

    assign w_rd_hit = (w_rd_addr >= ADDR_DUTY_BASE) && ({1'b0, w_rd_addr} < DUTY_END);

    always_comb begin
        w_rd_data = '0;
        case (w_rd_addr)
            ADDR_OUT_EN_LO: w_rd_data = r_out_en[7:0];
            ADDR_OUT_EN_HI: w_rd_data = r_out_en[15:8];
            ADDR_PWM_EN_LO: w_rd_data = r_pwm_en[7:0];
            ADDR_PWM_EN_HI: w_rd_data = r_pwm_en[15:8];
            ADDR_PRESCALE:  w_rd_data = r_prescale;
            default: if (w_rd_hit) w_rd_data = r_duty[w_rd_addr[3:0]];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_sh  <= '0;
            r_rd_act <= 1'b0;
            r_cipo   <= 1'b0;
        end else if (!w_busy) begin
            r_rd_act <= 1'b0;
            r_cipo   <= 1'b0;
        end else if (w_rd_start) begin
            r_rd_sh  <= w_rd_data;
            r_rd_act <= 1'b1;
        end else if (r_rd_act && w_sclk_fall) begin
            r_cipo  <= r_rd_sh[7];
            r_rd_sh <= {r_rd_sh[6:0], 1'b0};
        end
    end

    assign cipo = r_cipo;
`else
    logic w_unused;
    assign w_unused = ^{w_rd_addr, w_rd_start, w_sclk_fall, w_busy};
    assign cipo     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_pwm_array.sv
// Self-checking bench for spi_pwm_array against a register/PWM behaviour model.
// Readback checks are included when SPI_PWM_READBACK_EN is defined.
module tb_spi_pwm_array;

    localparam int NCH  = 16;
    localparam int SS   = 2;
    localparam int HALF = 6;

    logic           clk  = 1'b0;
    logic           rst  = 1'b1;
    logic           sclk = 1'b0;
    logic           copi = 1'b0;
    logic           cs_n = 1'b1;
    logic           cipo;
    logic [NCH-1:0] out;
    logic           frame_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int err_cyc = 0;
    int err_pulses = 0;
    int cipo_hi = 0;
    logic err_prev = 1'b0;

    logic [15:0] m_oe;
    logic [15:0] m_pe;
    logic [7:0]  m_pre;
    logic [7:0]  m_duty [NCH];

    always #5 clk = ~clk;

    spi_pwm_array #(
        .NUM_CH(NCH),
        .SYNC_STAGES(SS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sclk(sclk),
        .copi(copi),
        .cs_n(cs_n),
        .cipo(cipo),
        .out(out),
        .frame_err(frame_err)
    );

    always @(posedge clk) begin
        cyc++;
        if (frame_err) err_cyc++;
        if (frame_err && !err_prev) err_pulses++;
        err_prev = frame_err;
        if (cipo) cipo_hi++;
    end

    task automatic model_reset();
        m_oe = '0;
        m_pe = '0;
        m_pre = '0;
        for (int i = 0; i < NCH; i++) m_duty[i] = '0;
    endtask

    // High cycles of a channel over one full counter period.
    function automatic int exp_high(input int ch);
        int w;
        w = 256 * (int'(m_pre) + 1);
        if (!m_oe[ch]) return 0;
        if (!m_pe[ch] || m_duty[ch] == 8'hFF) return w;
        return int'(m_duty[ch]) * (int'(m_pre) + 1);
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            copi = w[31-i];
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [31:0] w, input int n);
        cs_n = 1'b0;
        wait_clk(HALF);
        spi_bits(w, n);
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
        spi_frame({1'b1, a, d, 16'h0}, 16);
        case (a)
            7'h00: m_oe[7:0] = d;
            7'h01: m_oe[15:8] = d;
            7'h02: m_pe[7:0] = d;
            7'h03: m_pe[15:8] = d;
            7'h04: m_pre = d;
            default: if (int'(a) >= 16 && int'(a) < 16 + NCH) m_duty[int'(a) - 16] = d;
        endcase
    endtask

    task automatic wait_level(input int ch, input logic lvl, input int lim, output int k);
        k = 0;
        while (out[ch] !== lvl && k < lim) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic count_high(input int ch, input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (out[ch]) hi++;
        end
    endtask

`ifdef SPI_PWM_READBACK_EN
    task automatic spi_read(input logic [6:0] a, output logic [7:0] got);
        logic [31:0] w;
        w = {1'b0, a, 24'h0};
        got = '0;
        cs_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 16; i++) begin
            copi = w[31-i];
            wait_clk(HALF);
            if (i >= 8) got[15-i] = cipo;
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(10);
    endtask
`endif

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(3);
        total++;
        if (out !== '0) begin bad++; $display("FAIL reset_out got=%h want=0", out); end
        total++;
        if (cipo !== 1'b0) begin bad++; $display("FAIL reset_cipo got=%b want=0", cipo); end
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", frame_err); end
        rst = 1'b0;
        model_reset();
        wait_clk(20);
        total++;
        if (out !== '0) begin bad++; $display("FAIL idle_out got=%h want=0", out); end
    endtask

    task automatic test_latency();
        int k;
        cs_n = 1'b0;
        wait_clk(HALF);
        spi_bits({1'b1, 7'h00, 8'h04, 16'h0}, 16);
        wait_clk(HALF);
        cs_n = 1'b1;
        m_oe[7:0] = 8'h04;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (out[2] !== 1'b1 && k < 20);
        total++;
        if (k != SS + 3) begin bad++; $display("FAIL write_latency got=%0d want=%0d", k, SS + 3); end
        wait_clk(10);
        total++;
        if (out !== m_oe) begin bad++; $display("FAIL latency_out got=%h want=%h", out, m_oe); end
    endtask

    task automatic test_pwm_basic();
        int h0;
        int h1;
        spi_write(7'h00, 8'h01);
        spi_write(7'h02, 8'h03);
        spi_write(7'h10, 8'h80);
        wait_clk(600);
        h0 = 0;
        h1 = 0;
        repeat (256) begin
            @(negedge clk);
            if (out[0]) h0++;
            if (out[1]) h1++;
        end
        total++;
        if (h0 != exp_high(0)) begin bad++; $display("FAIL basic_ch0 got=%0d want=%0d", h0, exp_high(0)); end
        total++;
        if (h1 != exp_high(1)) begin bad++; $display("FAIL basic_ch1 got=%0d want=%0d", h1, exp_high(1)); end
    endtask

    task automatic test_duty_ff_zero();
        int h;
        int k;
        spi_write(7'h10, 8'hFF);
        wait_clk(600);
        count_high(0, 256, h);
        total++;
        if (h != exp_high(0)) begin bad++; $display("FAIL duty_ff got=%0d want=%0d", h, exp_high(0)); end
        spi_write(7'h10, 8'h00);
        wait_level(0, 1'b0, 300, k);
        total++;
        if (k >= 300) begin bad++; $display("FAIL duty_zero_fall got=%0d want=<300", k); end
        count_high(0, 256, h);
        total++;
        if (h != exp_high(0)) begin bad++; $display("FAIL duty_zero got=%0d want=%0d", h, exp_high(0)); end
    endtask

    task automatic test_duty_change();
        int k;
        int t;
        int exp_old;
        int exp_new;
        spi_write(7'h04, 8'h03);
        spi_write(7'h10, 8'h40);
        wait_clk(3 * 1024);
        wait_level(0, 1'b0, 1100, k);
        wait_level(0, 1'b1, 1100, k);
        t = cyc;
        exp_old = exp_high(0);
        spi_write(7'h10, 8'hC0);
        exp_new = exp_high(0);
        wait_level(0, 1'b0, 1100, k);
        total++;
        if (cyc - t != exp_old) begin bad++; $display("FAIL change_cur got=%0d want=%0d", cyc - t, exp_old); end
        wait_level(0, 1'b1, 1100, k);
        t = cyc;
        wait_level(0, 1'b0, 1100, k);
        total++;
        if (cyc - t != exp_new) begin bad++; $display("FAIL change_next got=%0d want=%0d", cyc - t, exp_new); end
    endtask

    task automatic test_prescale();
        int k;
        int t;
        spi_write(7'h10, 8'h02);
        wait_clk(2200);
        wait_level(0, 1'b0, 1100, k);
        wait_level(0, 1'b1, 1100, k);
        t = cyc;
        wait_level(0, 1'b0, 1100, k);
        total++;
        if (cyc - t != exp_high(0)) begin bad++; $display("FAIL presc_high got=%0d want=%0d", cyc - t, exp_high(0)); end
        wait_level(0, 1'b1, 1100, k);
        total++;
        if (cyc - t != 256 * (int'(m_pre) + 1)) begin
            bad++; $display("FAIL presc_period got=%0d want=%0d", cyc - t, 256 * (int'(m_pre) + 1));
        end
    endtask

    task automatic test_frame_err();
        spi_write(7'h02, 8'h01);
        spi_write(7'h00, 8'h02);
        wait_clk(5);
        err_cyc = 0;
        err_pulses = 0;
        spi_frame({16'h8000, 16'h0}, 15);
        total++;
        if (err_cyc != 1 || err_pulses != 1) begin
            bad++; $display("FAIL short_frame_err got=%0d/%0d want=1/1", err_cyc, err_pulses);
        end
        total++;
        if (out[1:0] !== {m_oe[1], 1'b0}) begin bad++; $display("FAIL short_frame_oe got=%b want=%b", out[1:0], {m_oe[1], 1'b0}); end
        err_cyc = 0;
        err_pulses = 0;
        cs_n = 1'b0;
        wait_clk(1);
        cs_n = 1'b1;
        wait_clk(12);
        total++;
        if (err_cyc != 1 || err_pulses != 1) begin
            bad++; $display("FAIL empty_frame_err got=%0d/%0d want=1/1", err_cyc, err_pulses);
        end
        err_cyc = 0;
        spi_frame({1'b1, 7'h00, 8'h07, 1'b1, 15'h0}, 17);
        m_oe[7:0] = 8'h07;
        total++;
        if (err_cyc != 0 || out[2] !== m_oe[2]) begin
            bad++; $display("FAIL long_frame got=%0d/%b want=0/%b", err_cyc, out[2], m_oe[2]);
        end
        err_cyc = 0;
        spi_write(7'h7F, 8'hFF);
        total++;
        if (err_cyc != 0) begin bad++; $display("FAIL unmapped_err got=%0d want=0", err_cyc); end
    endtask

    task automatic test_read();
`ifdef SPI_PWM_READBACK_EN
        logic [7:0] got;
        spi_write(7'h04, 8'h55);
        spi_read(7'h04, got);
        total++;
        if (got !== m_pre) begin bad++; $display("FAIL read_presc got=%h want=%h", got, m_pre); end
        spi_read(7'h7F, got);
        total++;
        if (got !== 8'h00) begin bad++; $display("FAIL read_unmapped got=%h want=00", got); end
        spi_write(7'h04, 8'h03);
`else
        err_cyc = 0;
        cipo_hi = 0;
        spi_frame({16'h0400, 16'h0}, 16);
        total++;
        if (err_cyc != 0 || cipo_hi != 0) begin
            bad++; $display("FAIL read_off got=%0d/%0d want=0/0", err_cyc, cipo_hi);
        end
`endif
    endtask

    task automatic test_reset_midframe();
        logic [31:0] w;
`ifdef SPI_PWM_READBACK_EN
        spi_write(7'h04, 8'h55);
        w = {16'h0400, 16'h0};
        cs_n = 1'b0;
        wait_clk(HALF);
        spi_bits(w, 12);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        model_reset();
        cipo_hi = 0;
        spi_bits(w << 12, 4);
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(10);
        total++;
        if (cipo_hi != 0) begin bad++; $display("FAIL rst_read_cipo got=%0d want=0", cipo_hi); end
`endif
        w = {1'b1, 7'h00, 8'hFF, 16'h0};
        cs_n = 1'b0;
        wait_clk(HALF);
        spi_bits(w, 10);
        rst = 1'b1;
        wait_clk(2);
        total++;
        if (out !== '0 || cipo !== 1'b0) begin bad++; $display("FAIL rst_mid_out got=%h/%b want=0/0", out, cipo); end
        rst = 1'b0;
        model_reset();
        err_cyc = 0;
        spi_bits(w << 10, 6);
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(10);
        total++;
        if (err_cyc != 0 || out !== m_oe) begin
            bad++; $display("FAIL rst_abort got=%0d/%h want=0/%h", err_cyc, out, m_oe);
        end
        spi_write(7'h00, 8'h01);
        wait_clk(5);
        total++;
        if (out !== m_oe) begin bad++; $display("FAIL rst_next_write got=%h want=%h", out, m_oe); end
    endtask

    task automatic test_random();
        int ch;
        int nb;
        int sel;
        int w;
        int h;
        int hn;
        logic [7:0] d;
        logic [15:0] oem;
        logic [15:0] pem;
        logic [7:0] pre;
        for (int it = 0; it < 6; it++) begin
            ch = $urandom_range(0, NCH - 1);
            nb = (ch + 1) % NCH;
            d = 8'($urandom_range(0, 255));
            sel = $urandom_range(0, 5);
            if (sel == 0) d = 8'h00;
            if (sel == 1) d = 8'hFF;
            oem = ($urandom_range(0, 3) != 0) ? (16'h1 << ch) : 16'h0;
            pem = ($urandom_range(0, 1) != 0) ? (16'h1 << ch) : 16'h0;
            pre = 8'($urandom_range(0, 1));
            spi_write(7'h00, oem[7:0]);
            spi_write(7'h01, oem[15:8]);
            spi_write(7'h02, pem[7:0]);
            spi_write(7'h03, pem[15:8]);
            spi_write(7'(16 + ch), d);
            spi_write(7'h04, pre);
            w = 256 * (int'(pre) + 1);
            wait_clk(3 * w + 20);
            h = 0;
            hn = 0;
            repeat (w) begin
                @(negedge clk);
                if (out[ch]) h++;
                if (out[nb]) hn++;
            end
            total++;
            if (h != exp_high(ch)) begin
                bad++; $display("FAIL rand_ch%0d got=%0d want=%0d", ch, h, exp_high(ch));
            end
            total++;
            if (hn != exp_high(nb)) begin
                bad++; $display("FAIL rand_nb%0d got=%0d want=%0d", nb, hn, exp_high(nb));
            end
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_pwm_basic();
        test_duty_ff_zero();
        test_duty_change();
        test_prescale();
        test_frame_err();
        test_read();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
